fpmul_seq: RTL and testbench

- Sequencing and post-processing wrapper for single-precision FP multiply.
- Accepts two IEEE-754 binary32 operands over a REQ/ACK handshake and unpacks them.
- Resolves special cases locally. Otherwise drives the booth mantissa multiplier (BREQ/BACK/m1/m2/res), then normalizes, rounds and packs the 48-bit product into a binary32 result with exception flags.
- Sits directly upstream and downstream of booth: feeds its operands and consumes its product.

---
 rtl/fpmul_seq.sv | 245 ++++++++++++++++++++++++
 tb/tb_fpmul_seq.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/fpmul_seq.sv
// fpmul_seq: sequencing and post-processing wrapper for a binary32 multiply.
//
// Accepts two binary32 operands over REQ/ACK, resolves NaN/inf/zero operands
// locally, otherwise hands the 24-bit mantissas to the booth multiplier
// (BREQ/BACK/m1/m2/bres) and normalizes, rounds and packs the 48-bit product.
//
// Ports:
//   CLK, RSTK         clock (rising edge), asynchronous active-low reset
//   REQ, opa, opb     request and operands, sampled only in IDLE
//   BUSY              high in every state except IDLE
//   ACK               one-cycle done pulse; result/flags held afterwards
//   result            packed binary32 product
//   flg_*             invalid / overflow / underflow / inexact
//   BREQ, m1, m2      booth request and {hidden, fraction} operands
//   BACK, bres        booth done pulse and 48-bit product
//
// Build option: FPMUL_RNE_EN selects round-to-nearest-even; when undefined
// the product is truncated and overflow saturates to max finite.
module fpmul_seq #(
    parameter int          EXP_BIAS = 127,
    parameter logic [31:0] QNAN     = 32'h7FC00000
) (
    input  logic        CLK,
    input  logic        RSTK,
    input  logic        REQ,
    input  logic [31:0] opa,
    input  logic [31:0] opb,
    output logic        BUSY,
    output logic        ACK,
    output logic [31:0] result,
    output logic        flg_invalid,
    output logic        flg_overflow,
    output logic        flg_underflow,
    output logic        flg_inexact,
    output logic        BREQ,
    output logic [23:0] m1,
    output logic [23:0] m2,
    input  logic        BACK,
    input  logic [47:0] bres
);

    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_UNPACK   = 3'd1;
    localparam logic [2:0] S_MUL_WAIT = 3'd2;
    localparam logic [2:0] S_NORM     = 3'd3;
    localparam logic [2:0] S_ROUND    = 3'd4;
    localparam logic [2:0] S_DONE     = 3'd5;

    localparam logic [9:0] BIAS10 = EXP_BIAS[9:0];

    logic [2:0]        state_q, state_d;
    logic [31:0]       opa_q, opa_d, opb_q, opb_d;
    logic              sign_q, sign_d;
    logic signed [9:0] e_q, e_d;
    logic [47:0]       prod_q, prod_d;
    logic [22:0]       mant_q, mant_d;
    logic              g_q, g_d, s_q, s_d;
    logic [31:0]       res_q, res_d;
    logic              inv_q, inv_d, ovf_q, ovf_d, unf_q, unf_d, inx_q, inx_d;
    logic              breq_q, breq_d;
    logic [23:0]       m1_q, m1_d, m2_q, m2_d;

    // Operand classification (exp==0 counts as zero: denormals are flushed)
    logic [7:0]  ea, eb;
    logic [22:0] fa, fb;
    logic        a_nan, b_nan, a_inf, b_inf, a_zero, b_zero, sgn;
    logic [9:0]  e_sum;

    assign ea     = opa_q[30:23];
    assign eb     = opb_q[30:23];
    assign fa     = opa_q[22:0];
    assign fb     = opb_q[22:0];
    assign a_nan  = (ea == 8'hFF) && (fa != 23'd0);
    assign b_nan  = (eb == 8'hFF) && (fb != 23'd0);
    assign a_inf  = (ea == 8'hFF) && (fa == 23'd0);
    assign b_inf  = (eb == 8'hFF) && (fb == 23'd0);
    assign a_zero = (ea == 8'd0);
    assign b_zero = (eb == 8'd0);
    assign sgn    = opa_q[31] ^ opb_q[31];
    // Range 1+1-127 .. 254+254-127 fits a 10-bit two's-complement value
    assign e_sum  = {2'b00, ea} + {2'b00, eb} - BIAS10;

    // Rounding datapath, used in ROUND
    logic              up;
    logic [23:0]       mant_r;
    logic signed [9:0] e_r;

`ifdef FPMUL_RNE_EN
    assign up = g_q & (s_q | mant_q[0]);
`else
    assign up = 1'b0;
`endif
    assign mant_r = {1'b0, mant_q} + {23'd0, up};
    // A carry out leaves the fraction all-zero and bumps the exponent
    assign e_r    = e_q + $signed({9'd0, mant_r[23]});

    always_comb begin
        state_d = state_q;
        opa_d   = opa_q;
        opb_d   = opb_q;
        sign_d  = sign_q;
        e_d     = e_q;
        prod_d  = prod_q;
        mant_d  = mant_q;
        g_d     = g_q;
        s_d     = s_q;
        res_d   = res_q;
        inv_d   = inv_q;
        ovf_d   = ovf_q;
        unf_d   = unf_q;
        inx_d   = inx_q;
        breq_d  = breq_q;
        m1_d    = m1_q;
        m2_d    = m2_q;

        case (state_q)
            S_IDLE: begin
                if (REQ) begin
                    opa_d   = opa;
                    opb_d   = opb;
                    state_d = S_UNPACK;
                end
            end
            S_UNPACK: begin
                sign_d = sgn;
                {inv_d, ovf_d, unf_d, inx_d} = 4'b0000;
                state_d = S_DONE;
                if (a_nan || b_nan) begin
                    res_d = QNAN;
                    inv_d = 1'b1;
                end else if ((a_inf && b_zero) || (b_inf && a_zero)) begin
                    res_d = QNAN;
                    inv_d = 1'b1;
                end else if (a_inf || b_inf) begin
                    res_d = {sgn, 8'hFF, 23'd0};
                end else if (a_zero || b_zero) begin
                    res_d = {sgn, 31'd0};
                end else begin
                    e_d     = $signed(e_sum);
                    m1_d    = {1'b1, fa};
                    m2_d    = {1'b1, fb};
                    breq_d  = 1'b1;
                    state_d = S_MUL_WAIT;
                end
            end
            S_MUL_WAIT: begin
                if (BACK) begin
                    prod_d  = bres;
                    breq_d  = 1'b0;
                    state_d = S_NORM;
                end
            end
            S_NORM: begin
                if (prod_q[47]) begin
                    mant_d = prod_q[46:24];
                    g_d    = prod_q[23];
                    s_d    = |prod_q[22:0];
                    e_d    = e_q + 10'sd1;
                end else begin
                    mant_d = prod_q[45:23];
                    g_d    = prod_q[22];
                    s_d    = |prod_q[21:0];
                end
                state_d = S_ROUND;
            end
            S_ROUND: begin
                inv_d = 1'b0;
                ovf_d = 1'b0;
                unf_d = 1'b0;
                // Underflow is judged on the exponent before rounding
                if (e_q <= 10'sd0) begin
                    res_d = {sign_q, 31'd0};
                    unf_d = 1'b1;
                    inx_d = 1'b1;
                end else if (e_r >= 10'sd255) begin
`ifdef FPMUL_RNE_EN
                    res_d = {sign_q, 8'hFF, 23'd0};
`else
                    res_d = {sign_q, 31'h7F7FFFFF};
`endif
                    ovf_d = 1'b1;
                    inx_d = 1'b1;
                end else begin
                    res_d = {sign_q, e_r[7:0], mant_r[22:0]};
                    inx_d = g_q | s_q;
                end
                state_d = S_DONE;
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RSTK) begin
        if (!RSTK) begin
            state_q <= S_IDLE;
            opa_q   <= '0;
            opb_q   <= '0;
            sign_q  <= 1'b0;
            e_q     <= '0;
            prod_q  <= '0;
            mant_q  <= '0;
            g_q     <= 1'b0;
            s_q     <= 1'b0;
            res_q   <= '0;
            inv_q   <= 1'b0;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
            inx_q   <= 1'b0;
            breq_q  <= 1'b0;
            m1_q    <= '0;
            m2_q    <= '0;
        end else begin
            state_q <= state_d;
            opa_q   <= opa_d;
            opb_q   <= opb_d;
            sign_q  <= sign_d;
            e_q     <= e_d;
            prod_q  <= prod_d;
            mant_q  <= mant_d;
            g_q     <= g_d;
            s_q     <= s_d;
            res_q   <= res_d;
            inv_q   <= inv_d;
            ovf_q   <= ovf_d;
            unf_q   <= unf_d;
            inx_q   <= inx_d;
            breq_q  <= breq_d;
            m1_q    <= m1_d;
            m2_q    <= m2_d;
        end
    end

    assign BUSY          = (state_q != S_IDLE);
    assign ACK           = (state_q == S_DONE);
    assign result        = res_q;
    assign flg_invalid   = inv_q;
    assign flg_overflow  = ovf_q;
    assign flg_underflow = unf_q;
    assign flg_inexact   = inx_q;
    assign BREQ          = breq_q;
    assign m1            = m1_q;
    assign m2            = m2_q;

endmodule

// File: tb/tb_fpmul_seq.sv
// Directed bench for fpmul_seq with a behavioural booth responder.
module tb_fpmul_seq;

    logic        CLK = 1'b0;
    logic        RSTK;
    logic        REQ;
    logic [31:0] opa, opb;
    logic        BUSY, ACK;
    logic [31:0] result;
    logic        flg_invalid, flg_overflow, flg_underflow, flg_inexact;
    logic        BREQ;
    logic [23:0] m1, m2;
    logic        BACK;
    logic [47:0] bres;

    fpmul_seq dut (
        .CLK(CLK), .RSTK(RSTK), .REQ(REQ), .opa(opa), .opb(opb),
        .BUSY(BUSY), .ACK(ACK), .result(result),
        .flg_invalid(flg_invalid), .flg_overflow(flg_overflow),
        .flg_underflow(flg_underflow), .flg_inexact(flg_inexact),
        .BREQ(BREQ), .m1(m1), .m2(m2), .BACK(BACK), .bres(bres)
    );

    always #5 CLK = ~CLK;

`ifdef FPMUL_RNE_EN
    localparam logic [31:0] EXP_RND = 32'h3FC00002;
    localparam logic [31:0] EXP_OVF = 32'h7F800000;
`else
    localparam logic [31:0] EXP_RND = 32'h3FC00001;
    localparam logic [31:0] EXP_OVF = 32'h7F7FFFFF;
`endif

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
        logic [3:0]  flg;   // {invalid, overflow, underflow, inexact}
        logic        special;
    } vec_t;

    localparam int NV = 13;
    vec_t vecs[NV];

    int ntests = 0;
    int nfail  = 0;

    // Booth responder: answers BREQ after bdelay further cycles with m1*m2
    int bdelay = 0;
    int bcnt   = 0;
    int breq_rises = 0;
    logic breq_prev = 1'b0;

    initial begin
        BACK = 1'b0;
        bres = '0;
        forever begin
            @(negedge CLK);
            BACK = 1'b0;
            if (BREQ && !breq_prev) breq_rises++;
            breq_prev = BREQ;
            if (!BREQ) bcnt = 0;
            else if (bcnt == bdelay) begin
                BACK = 1'b1;
                bres = {24'd0, m1} * {24'd0, m2};
                bcnt = 0;
            end else bcnt++;
        end
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        ntests++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic run_op(input logic [31:0] a, input logic [31:0] b, input int dly,
                          output logic [31:0] r, output logic [3:0] f, output int lat,
                          output int ackw, output int nbreq,
                          output logic busy_ack, output logic busy_after);
        int r0;
        r0 = breq_rises;
        bdelay = dly;
        @(negedge CLK);
        opa = a; opb = b; REQ = 1'b1;
        @(posedge CLK);
        #1 REQ = 1'b0;
        lat = 0;
        while (lat < 200) begin
            @(negedge CLK);
            lat++;
            if (ACK) break;
        end
        r = result;
        f = {flg_invalid, flg_overflow, flg_underflow, flg_inexact};
        busy_ack = BUSY;
        ackw = ACK ? 1 : 0;
        @(negedge CLK);
        if (ACK) ackw++;
        busy_after = BUSY;
        nbreq = breq_rises - r0;
    endtask

    initial begin
        logic [31:0] r;
        logic [3:0]  f;
        int lat, ackw, nbreq, wcnt;
        logic ba, bf;

        vecs[0]  = '{32'h3FC00000, 32'h40000000, 32'h40400000, 4'b0000, 1'b0};
        vecs[1]  = '{32'h7F800000, 32'h00000000, 32'h7FC00000, 4'b1000, 1'b1};
        vecs[2]  = '{32'h3F800001, 32'h3FC00000, EXP_RND,      4'b0001, 1'b0};
        vecs[3]  = '{32'h7F000000, 32'h7F000000, EXP_OVF,      4'b0101, 1'b0};
        vecs[4]  = '{32'h00800000, 32'h3F000000, 32'h00000000, 4'b0011, 1'b0};
        vecs[5]  = '{32'h7FC00000, 32'h3F800000, 32'h7FC00000, 4'b1000, 1'b1};
        vecs[6]  = '{32'h7F800000, 32'hC0000000, 32'hFF800000, 4'b0000, 1'b1};
        vecs[7]  = '{32'h80000000, 32'h40400000, 32'h80000000, 4'b0000, 1'b1};
        vecs[8]  = '{32'hBFC00000, 32'h40000000, 32'hC0400000, 4'b0000, 1'b0};
        vecs[9]  = '{32'h3FFFFFFF, 32'h3F800001, 32'h40000000, 4'b0001, 1'b0};
        vecs[10] = '{32'h00000001, 32'h3F800000, 32'h00000000, 4'b0000, 1'b1};
        vecs[11] = '{32'h00000000, 32'h7F800000, 32'h7FC00000, 4'b1000, 1'b1};
        vecs[12] = '{32'h7F800001, 32'h00000000, 32'h7FC00000, 4'b1000, 1'b1};

        RSTK = 1'b0; REQ = 1'b0; opa = '0; opb = '0;
        #12;
        chk("reset_ctl", 64'({BUSY, ACK, BREQ, flg_invalid, flg_overflow,
                              flg_underflow, flg_inexact}), 64'd0);
        chk("reset_result", 64'(result), 64'd0);
        chk("reset_m", 64'({m1, m2}), 64'd0);
        @(negedge CLK);
        RSTK = 1'b1;
        @(negedge CLK);
        chk("idle_busy", 64'(BUSY), 64'd0);

        for (int i = 0; i < NV; i++) begin
            run_op(vecs[i].a, vecs[i].b, i % 4, r, f, lat, ackw, nbreq, ba, bf);
            chk($sformatf("v%0d_result", i), 64'(r), 64'(vecs[i].res));
            chk($sformatf("v%0d_flags", i), 64'(f), 64'(vecs[i].flg));
            chk($sformatf("v%0d_ackw", i), 64'(ackw), 64'd1);
            chk($sformatf("v%0d_busy", i), 64'({ba, bf}), 64'b10);
            if (vecs[i].special) begin
                chk($sformatf("v%0d_breq", i), 64'(nbreq), 64'd0);
                chk($sformatf("v%0d_lat", i), 64'(lat), 64'd2);
            end else begin
                chk($sformatf("v%0d_breq", i), 64'(nbreq), 64'd1);
                chk($sformatf("v%0d_lat", i), 64'(lat), 64'(i % 4 + 5));
            end
        end

        // Reset asserted while waiting on a slow booth
        bdelay = 30;
        @(negedge CLK);
        opa = 32'h40000000; opb = 32'h40000000; REQ = 1'b1;
        @(posedge CLK);
        #1 REQ = 1'b0;
        wcnt = 0;
        while (!BREQ && wcnt < 10) begin
            @(negedge CLK);
            wcnt++;
        end
        chk("midrst_breq_seen", 64'(BREQ), 64'd1);
        @(negedge CLK);
        #2 RSTK = 1'b0;
        #1;
        chk("midrst_drop", 64'({BREQ, ACK, BUSY}), 64'd0);
        repeat (2) @(negedge CLK);
        RSTK = 1'b1;
        run_op(32'h40000000, 32'h40000000, 2, r, f, lat, ackw, nbreq, ba, bf);
        chk("postrst_result", 64'(r), 64'h40800000);
        chk("postrst_flags", 64'(f), 64'd0);
        chk("postrst_lat", 64'(lat), 64'd7);

        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule
